dc_planar_hier_decider: RTL
===========================

Name: dc_planar_hier_decider

Overview:
Parametrised successor to the fixed-timing DC/planar override stage in the pre-intra path. It accumulates gradient activity |gx|+|gy| per 8x8 block and aggregates it in z-order to 16x16 and 32x32. When an angular cost result arrives for a level, it decides that level's final mode: DC, planar or angular pass-through. Timing is driven by valid/last strobes and a block index rather than free-running counters, and both thresholds are runtime ports. The block sits between the gradient generator and the mode-cost comparator, feeding the final intra mode list.

Parameters:
GW, 11, signed gradient width.
MB_W, 22, width of 8x8 angular cost; 16x16 cost uses MB_W+2, 32x32 uses MB_W+4 (one shared port of MB_W+4 bits).
PLAN_SHIFT, 5, planar factor = 2^PLAN_SHIFT (32).
DEF_LVL_EN, 3'b111, reset value of level enable (bit0=8x8, bit1=16x16, bit2=32x32).

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
flush  in  1  synchronous clear of accumulators, pending flags and ovf
g_valid  in  1  gradient sample valid
gx  in  GW  signed horizontal gradient
gy  in  GW  signed vertical gradient
g_last  in  1  qualifies 64th sample of current 8x8 block
blk_idx  in  4  z-order index of current 8x8 within its 32x32; sampled with g_last
lvl_en  in  3  per-level enable, static while busy
dc_thr8/dc_thr16/dc_thr32  in  GW+7/GW+9/GW+11  DC thresholds (activity < thr forces DC)
cost_valid  in  1  angular result valid
cost_lvl  in  2  0=8x8, 1=16x16, 2=32x32; 3 illegal
cost_mode  in  6  best angular mode
cost_sad  in  MB_W+4  best angular cost (zero-extended)
mode_valid  out  1  decision strobe
mode_lvl  out  2  level of decision
mode_out  out  6  final mode
mode_src  out  2  0=angular, 1=DC forced, 2=planar forced, 3=no activity (pass-through)
mode_err  out  1  one-cycle pulse: cost without pending activity, or cost_lvl=3
ovf  out  1  sticky: activity finalised while same-level result still pending

Behaviour:
- Reset and flush: all outputs 0, all accumulators 0, all pending flags 0.
- Stage 1, cycle t+1 after a valid sample at t: register a = |gx|+|gy| as GW+1 bits unsigned. abs(-2^(GW-1)) = 2^(GW-1) exactly; no wrap.
- Stage 2:
  - acc8 (GW+7 bits) += a for each valid sample.
  - On a g_last sample: act8 <= acc8+a, acc8 <= 0, pend8 <= 1 (if lvl_en[0]). act8 is visible at t+2.
  - No saturation is needed; widths are exact for 64/256/1024 samples.
- Stage 3, t+3: act16 (GW+9 bits).
  - blk_idx[1:0]==0: act16 <= act8.
  - Otherwise: act16 <= act16 + act8.
  - blk_idx[1:0]==3: pend16 <= 1.
- Stage 4, t+4: act32 (GW+11 bits) accumulates act16 on each completed quad.
  - Load on blk_idx==3, add otherwise.
  - blk_idx==15: pend32 <= 1.
- Disabled level: pend flag never set; accumulation still runs.
- Decision for cost_valid at cycle c; outputs registered at c+1, mode_valid high exactly one cycle.
  - Priority:
    1. No pending activity for the level: mode_out=cost_mode, src=3, mode_err=1.
    2. act < dc_thr: mode_out=1, src=1.
    3. cost_sad > (act << PLAN_SHIFT), full-width compare with no truncation: mode_out=0, src=2.
    4. Otherwise: mode_out=cost_mode, src=0.
  - The level's pend flag is cleared.
- cost_lvl=3: mode_valid=1, mode_out=cost_mode, src=3, mode_err=1.
- Simultaneous finalise and cost for the same level:
  - The decision uses the old registered act and pend.
  - The new act becomes pending.
  - If the old pend was 0: error path.
- Finalise while pend=1: overwrite act, set ovf (sticky until reset/flush).
- g_valid low stalls all stages in place; there are no bubbles in accumulation.
- Reset or flush mid-block discards the partial block; the next sample starts a fresh acc8.

Test Plan:
1. DC forcing: 64 samples gx=gy=0, idx=0, dc_thr8=288; cost lvl0 mode 26 sad 5000 -> mode_out=1, src=1, one cycle after cost.
2. Planar boundary: 64 samples gx=3, gy=-2 -> act8=320.
   - sad=10241 -> mode_out=0, src=2.
   - Repeat with sad=10240 -> mode_out=26, src=0.
3. Width extremes: 64 samples gx=gy=-1024 -> act8=131072, no wrap; dc_thr8=131073 -> DC forced.
4. 16x16 aggregation: idx 0..3, each block act8=320 -> act16=1280, dc_thr16=1152; cost lvl1 sad 40961 -> planar, sad 40960 -> angular.
5. 32x32 aggregation: idx 0..15, all-zero gradients; cost lvl2 mode 10 -> mode_out=1, src=1. A second lvl2 cost -> src=3, mode_err pulse.
6. Faults: two g_last blocks with no cost -> ovf=1; rstn low mid-block -> all outputs 0; flush -> ovf=0.

Source files
------------

// File: rtl/dc_planar_hier_decider_if.sv
// dc_planar_hier_decider_if: gradient, thresholds, angular cost and final-mode bundle for the DC/planar decider
interface dc_planar_hier_decider_if #(
  parameter int GW = 11,
  parameter int MB_W = 22
);
  logic flush;
  logic g_valid;
  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic g_last;
  logic [3:0] blk_idx;
  logic [2:0] lvl_en;
  logic [GW+6:0] dc_thr8;
  logic [GW+8:0] dc_thr16;
  logic [GW+10:0] dc_thr32;
  logic cost_valid;
  logic [1:0] cost_lvl;
  logic [5:0] cost_mode;
  logic [MB_W+3:0] cost_sad;
  logic mode_valid;
  logic [1:0] mode_lvl;
  logic [5:0] mode_out;
  logic [1:0] mode_src;
  logic mode_err;
  logic ovf;
  modport master (
    output flush, g_valid, gx, gy, g_last, blk_idx, lvl_en, dc_thr8, dc_thr16, dc_thr32,
    output cost_valid, cost_lvl, cost_mode, cost_sad,
    input mode_valid, mode_lvl, mode_out, mode_src, mode_err, ovf
  );
  modport slave (
    input flush, g_valid, gx, gy, g_last, blk_idx, lvl_en, dc_thr8, dc_thr16, dc_thr32,
    input cost_valid, cost_lvl, cost_mode, cost_sad,
    output mode_valid, mode_lvl, mode_out, mode_src, mode_err, ovf
  );
endinterface

// File: rtl/dc_planar_hier_decider.sv
// dc_planar_hier_decider: z-order 8/16/32 gradient activity accumulation and DC/planar/angular final mode decision
module dc_planar_hier_decider #(
  parameter int GW = 11,
  parameter int MB_W = 22,
  parameter int PLAN_SHIFT = 5,
  parameter logic [2:0] DEF_LVL_EN = 3'b111
) (
  input logic clk,
  input logic rstn,
  dc_planar_hier_decider_if.slave bus
);
  localparam int A8W = GW + 7;
  localparam int A16W = GW + 9;
  localparam int A32W = GW + 11;
  localparam int SW = MB_W + 4;
  localparam int CW = (SW > A32W + PLAN_SHIFT) ? SW : A32W + PLAN_SHIFT;
  logic [GW-1:0] w_ax, w_ay;
  logic [GW:0] w_a;
  logic [2:0] r_lvl_en;
  logic r_v1, r_last1, r_fin8, r_fin16;
  logic [3:0] r_idx1, r_idx2, r_idx3;
  logic [GW:0] r_a;
  logic [A8W-1:0] r_acc8, r_act8, w_sum8;
  logic [A16W-1:0] r_act16, w_ext8;
  logic [A32W-1:0] r_act32, w_ext16;
  logic [2:0] r_pend, w_fin, w_clr;
  logic [CW-1:0] w_act, w_thr;
  logic w_pnd, w_dc, w_pl;
  // the two's complement negate of the most negative value lands on 2^(GW-1) when read unsigned
  assign w_ax = bus.gx[GW-1] ? ~bus.gx + 1'b1 : bus.gx;
  assign w_ay = bus.gy[GW-1] ? ~bus.gy + 1'b1 : bus.gy;
  assign w_a = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_sum8 = r_acc8 + {{(A8W-GW-1){1'b0}}, r_a};
  assign w_ext8 = {{(A16W-A8W){1'b0}}, r_act8};
  assign w_ext16 = {{(A32W-A16W){1'b0}}, r_act16};
  assign w_fin = {r_fin16 & (r_idx3 == 4'd15), r_fin8 & (r_idx2[1:0] == 2'd3), r_v1 & r_last1};
  assign w_clr = {3{bus.cost_valid}} & {bus.cost_lvl == 2'd2, bus.cost_lvl == 2'd1, bus.cost_lvl == 2'd0};
  assign w_pnd = |(w_clr & r_pend);
  assign w_act = (bus.cost_lvl == 2'd0) ? CW'(r_act8) : (bus.cost_lvl == 2'd1) ? CW'(r_act16) : CW'(r_act32);
  assign w_thr = (bus.cost_lvl == 2'd0) ? CW'(bus.dc_thr8) : (bus.cost_lvl == 2'd1) ? CW'(bus.dc_thr16) : CW'(bus.dc_thr32);
  assign w_dc = w_act < w_thr;
  assign w_pl = CW'(bus.cost_sad) > (w_act << PLAN_SHIFT);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_lvl_en <= DEF_LVL_EN;
    else r_lvl_en <= bus.lvl_en;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {r_v1, r_last1, r_fin8, r_fin16, r_idx1, r_idx2, r_idx3, r_a} <= '0;
      {r_acc8, r_act8, r_act16, r_act32, r_pend, bus.ovf} <= '0;
    end else if (bus.flush) begin
      {r_v1, r_last1, r_fin8, r_fin16, r_idx1, r_idx2, r_idx3, r_a} <= '0;
      {r_acc8, r_act8, r_act16, r_act32, r_pend, bus.ovf} <= '0;
    end else begin
      r_v1 <= bus.g_valid;
      if (bus.g_valid) begin
        r_a <= w_a;
        r_last1 <= bus.g_last;
        r_idx1 <= bus.blk_idx;
      end
      if (r_v1) r_acc8 <= r_last1 ? '0 : w_sum8;
      if (w_fin[0]) begin
        r_act8 <= w_sum8;
        r_idx2 <= r_idx1;
      end
      r_fin8 <= w_fin[0];
      if (r_fin8) begin
        r_act16 <= (r_idx2[1:0] == 2'd0) ? w_ext8 : r_act16 + w_ext8;
        r_idx3 <= r_idx2;
      end
      r_fin16 <= w_fin[1];
      if (r_fin16) r_act32 <= (r_idx3 == 4'd3) ? w_ext16 : r_act32 + w_ext16;
      // a same-cycle decision consumes the old pend while the fresh activity re-arms it
      r_pend <= (r_pend & ~w_clr) | (w_fin & r_lvl_en);
      bus.ovf <= bus.ovf | (|(w_fin & r_pend));
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {bus.mode_valid, bus.mode_lvl, bus.mode_out, bus.mode_src, bus.mode_err} <= '0;
    end else if (bus.flush) begin
      {bus.mode_valid, bus.mode_lvl, bus.mode_out, bus.mode_src, bus.mode_err} <= '0;
    end else begin
      bus.mode_valid <= bus.cost_valid;
      bus.mode_err <= bus.cost_valid & ~w_pnd;
      if (bus.cost_valid) begin
        bus.mode_lvl <= bus.cost_lvl;
        bus.mode_src <= !w_pnd ? 2'd3 : w_dc ? 2'd1 : w_pl ? 2'd2 : 2'd0;
        bus.mode_out <= (w_pnd & w_dc) ? 6'd1 : (w_pnd & w_pl) ? 6'd0 : bus.cost_mode;
      end
    end
  end
endmodule
